// File: rtl/spi_defs_pkg.sv
// Shared definitions for the SPI byte receiver: select polarity, the minimum
// synchroniser depth and the frame state encoding.
package spi_defs;

  localparam logic SPI_SS_ACTIVE       = 1'b0;
  localparam int   SPI_SYNC_STAGES_MIN = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_byte_rx_sync_edge.sv
// Pin synchroniser with a registered edge detector. The level output is the
// extra registered copy, so every instance presents data with the same delay
// as the rise/fall strobes and a level-only user (mosi) stays aligned with
// the sclk strobes.
module sync_edge #(
  parameter int   stages  = 2,
  parameter logic rst_val = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [stages-1:0] chain;
  logic              prev;

  // Synchronise the pin, keep one delayed copy and register the edge strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {stages{rst_val}};
      prev  <= rst_val;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[stages-2:0], pin};
      prev  <= chain[stages-1];
      rise  <= chain[stages-1] & ~prev;
      fall  <= ~chain[stages-1] & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI slave receiver. Pins are oversampled in the clk domain; received
// words come out on data/valid, a status word is shifted back on spi_miso.
module spi_byte_rx
  import spi_defs::*;
#(
  parameter int bitwidth    = 8,
  parameter int sync_stages = 2,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sclk,
  input  logic                   spi_ss,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [bitwidth-1:0]    tx_data,
  output logic [bitwidth-1:0]    data,
  output logic                   valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic [count_width-1:0] byte_count
);

  // Shallower synchronisers than the minimum are silently deepened.
  localparam int STAGES = (sync_stages < SPI_SYNC_STAGES_MIN) ? SPI_SYNC_STAGES_MIN : sync_stages;
  localparam int BCW    = (bitwidth > 2) ? $clog2(bitwidth) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(bitwidth - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic ss_select, ss_deselect;
  logic unused_pins;

  spi_state_t          state;
  logic [BCW-1:0]      bit_cnt;
  logic [bitwidth-1:0] rx_sr;
  logic [bitwidth-1:0] rx_next;
  logic [bitwidth-1:0] tx_sr;
  logic                reload;

  // Saturating word counter increment.
  function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sync_edge #(.stages(STAGES), .rst_val(1'b0)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_sclk),
    .level(sclk_level),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.stages(STAGES), .rst_val(~SPI_SS_ACTIVE)) u_ss (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_ss),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  sync_edge #(.stages(STAGES), .rst_val(1'b0)) u_mosi (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_mosi),
    .level(mosi_level),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  // Only the sclk/ss strobes and the mosi level drive the datapath.
  assign unused_pins = ^{mosi_rise, mosi_fall, sclk_level, ss_level};

  assign ss_select   = (SPI_SS_ACTIVE == 1'b0) ? ss_fall : ss_rise;
  assign ss_deselect = (SPI_SS_ACTIVE == 1'b0) ? ss_rise : ss_fall;
  assign rx_next     = {rx_sr[bitwidth-2:0], mosi_level};

  // Frame FSM with receive shifting, word delivery and transmit shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      reload      <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      byte_count  <= '0;
      spi_miso    <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ss_select) begin
            state       <= ST_ACTIVE;
            frame_start <= 1'b1;
            byte_count  <= '0;
            reload      <= 1'b0;
            tx_sr       <= tx_data;
            spi_miso    <= tx_data[bitwidth-1];
            // An sclk rise seen together with select is bit 0 of the frame.
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= BCW'(1);
            end else begin
              bit_cnt <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (sclk_rise) begin
            rx_sr <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              data       <= rx_next;
              valid      <= 1'b1;
              byte_count <= sat_inc(byte_count);
              reload     <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload) begin
              tx_sr    <= tx_data;
              spi_miso <= tx_data[bitwidth-1];
              reload   <= 1'b0;
            end else begin
              tx_sr    <= {tx_sr[bitwidth-2:0], 1'b0};
              spi_miso <= tx_sr[bitwidth-2];
            end
          end
          // Deselect wins over everything except a word completed this cycle.
          if (ss_deselect) begin
            state     <= ST_IDLE;
            frame_end <= 1'b1;
            bit_cnt   <= '0;
            reload    <= 1'b0;
            spi_miso  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Bench for spi_byte_rx: a host model drives SPI frames at f_clk/8, a monitor
// records the strobes, and each frame is compared against the words the host
// sent and the status words it should have read back.
module tb_spi_byte_rx;

  localparam int H = 4;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_ss, spi_mosi;
  logic [7:0]  tx_data;
  logic        spi_miso, valid, frame_start, frame_end;
  logic [7:0]  data;
  logic [15:0] byte_count;
  logic        miso2, valid2, fs2, fe2;
  logic [7:0]  data2;
  logic [1:0]  bc2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_byte_rx #(.bitwidth(8), .sync_stages(2), .count_width(16)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .data(data), .valid(valid),
    .frame_start(frame_start), .frame_end(frame_end), .byte_count(byte_count)
  );

  spi_byte_rx #(.bitwidth(8), .sync_stages(2), .count_width(2)) dut_sat (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(miso2), .tx_data(tx_data), .data(data2), .valid(valid2),
    .frame_start(fs2), .frame_end(fe2), .byte_count(bc2)
  );

  // Strobe monitor, sampled on the inactive clock edge.
  logic [7:0] vq[$];
  logic [7:0] v2q[$];
  int fs_cnt = 0;
  int fe_cnt = 0;
  int fe2_cnt = 0;
  always @(negedge clk) begin
    if (valid)  vq.push_back(data);
    if (valid2) v2q.push_back(data2);
    if (frame_start) fs_cnt++;
    if (frame_end)   fe_cnt++;
    if (fe2)         fe2_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit: present mosi while sclk is low, host samples miso at the rise.
  task automatic xfer_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_cyc(H);
    m = spi_miso;
    spi_sclk = 1'b1;
    wait_cyc(H);
    spi_sclk = 1'b0;
  endtask

  // One word, MSB first; optionally changes tx_data in the middle of the word.
  task automatic xfer_word(input logic [7:0] b, input logic chg, input logic [7:0] newtx,
                           output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i], mb);
      m[i] = mb;
      if (chg && i == 4) tx_data = newtx;
    end
  endtask

  // Full frame plus checks against the expected words, counts and status bytes.
  task automatic run_frame(input logic [0:7][7:0] fb, input int n, input int partial,
                           input logic [7:0] pbits, input logic [7:0] tx0, input logic chg,
                           input int exp_n, input int exp_cnt, input int exp_sat);
    int v0, v20, fs0, fe0, f20;
    logic [7:0] exp_tx, ntx, m, got;
    logic mb;
    v0 = vq.size(); v20 = v2q.size(); fs0 = fs_cnt; fe0 = fe_cnt; f20 = fe2_cnt;
    tx_data = tx0;
    spi_ss = 1'b0;
    wait_cyc(H);
    exp_tx = tx0;
    for (int k = 0; k < n; k++) begin
      ntx = chg ? 8'($urandom) : exp_tx;
      xfer_word(fb[k], chg, ntx, m);
      chk("miso_word", m, exp_tx);
      exp_tx = ntx;
    end
    for (int j = 0; j < partial; j++) xfer_bit(pbits[7-j], mb);
    wait_cyc(H);
    spi_ss = 1'b1;
    wait_cyc(3 * H);
    chk("valid_count", vq.size() - v0, exp_n);
    for (int k = 0; k < exp_n; k++) begin
      got = (v0 + k < vq.size()) ? vq[v0 + k] : 8'hxx;
      chk("data_word", got, fb[k]);
    end
    chk("byte_count", byte_count, exp_cnt);
    chk("byte_count_sat", bc2, exp_sat);
    chk("valid_count_sat", v2q.size() - v20, exp_n);
    chk("frame_start_pulses", fs_cnt - fs0, 1);
    chk("frame_end_pulses", fe_cnt - fe0, 1);
    chk("frame_end_pulses_sat", fe2_cnt - f20, 1);
  endtask

  typedef struct {
    int              n;
    logic [0:7][7:0] b;
    int              partial;
    logic [7:0]      pbits;
    logic [7:0]      tx;
    int              exp_n;
    int              exp_cnt;
    int              exp_sat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int v0, lat, vcyc, fe_at, n, partial;
    logic [7:0] d, pb;
    logic mb;
    logic [0:7][7:0] fb;

    tbl[0] = '{2, 64'hA53C_0000_0000_0000, 0, 8'h00, 8'h81, 2, 2, 2};
    tbl[1] = '{0, 64'h0,                   5, 8'hF8, 8'h00, 0, 0, 0};
    tbl[2] = '{1, 64'h5A00_0000_0000_0000, 0, 8'h00, 8'h3C, 1, 1, 1};
    tbl[3] = '{5, 64'hDEAD_BEEF_4200_0000, 0, 8'h00, 8'hC3, 5, 5, 3};

    // Reset with the pins idle.
    rst = 1'b0; spi_ss = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; tx_data = 8'h00;
    wait_cyc(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    chk("rst_byte_count", byte_count, 16'h0);
    chk("rst_miso", spi_miso, 1'b0);
    rst = 1'b1;
    wait_cyc(100);
    chk("idle_no_valid", vq.size(), 0);
    chk("idle_no_frame_start", fs_cnt, 0);
    chk("idle_no_frame_end", fe_cnt, 0);

    // Table of frames.
    for (int r = 0; r < 4; r++)
      run_frame(tbl[r].b, tbl[r].n, tbl[r].partial, tbl[r].pbits, tbl[r].tx, 1'b0,
                tbl[r].exp_n, tbl[r].exp_cnt, tbl[r].exp_sat);

    // Final bit rise together with deselect.
    tx_data = 8'h55;
    spi_ss = 1'b0;
    wait_cyc(H);
    for (int i = 0; i < 7; i++) xfer_bit(1'b1, mb);
    spi_mosi = 1'b1;
    wait_cyc(H);
    v0 = vq.size();
    spi_sclk = 1'b1;
    spi_ss = 1'b1;
    lat = -1; vcyc = 0; fe_at = 0; d = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      wait_cyc(1);
      if (valid) begin
        vcyc++;
        if (lat < 0) begin
          lat = i; fe_at = frame_end; d = data;
        end
      end
    end
    spi_sclk = 1'b0;
    wait_cyc(3 * H);
    chk("simul_valid_latency", lat, 4);
    chk("simul_frame_end_with_valid", fe_at, 1);
    chk("simul_data", d, 8'hFF);
    chk("simul_valid_width", vcyc, 1);
    chk("simul_valid_count", vq.size() - v0, 1);

    // Reset in the middle of a word.
    tx_data = 8'hF0;
    spi_ss = 1'b0;
    wait_cyc(H);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, mb);
    wait_cyc(H);
    chk("pre_reset_miso", spi_miso, 1'b1);
    v0 = vq.size();
    rst = 1'b0;
    #1;
    chk("async_rst_data", data, 8'h00);
    chk("async_rst_miso", spi_miso, 1'b0);
    chk("async_rst_byte_count", byte_count, 16'h0);
    spi_ss = 1'b1;
    spi_sclk = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(10);
    chk("no_valid_after_reset", vq.size() - v0, 0);
    run_frame(64'h1200_0000_0000_0000, 1, 0, 8'h00, 8'hA7, 1'b0, 1, 1, 1);
    chk("post_reset_data", data, 8'h12);

    // Randomised frames against the frame model.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 5);
      partial = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      pb = 8'($urandom);
      run_frame(fb, n, partial, pb, 8'($urandom), 1'b1, n, n, (n > 3) ? 3 : n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
